seg7_display: RTL and testbench

Display-side consumer of the calculator SoC's 8-bit `dout` bus. Takes the signed two's-complement result, converts its magnitude to BCD with a sequential shift-add-3 engine, and drives a 4-digit common-anode seven-segment display by time multiplexing. Sits at the top level next to `soc`, with `dout` wired to `value`.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/bin2bcd_seq.sv | 60 ++++++
 rtl/seg7_display.sv | 134 +++++++++++++
 tb/tb_seg7_display.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, constants and segment encoding for the seven-segment display block.
package seg7_pkg;

    localparam int unsigned BIN_W  = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Active-low {g,f,e,d,c,b,a} pattern for a decimal nibble.
    function automatic logic [6:0] nib2seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: 8 shift cycles per conversion.
// done is asserted during the final shift cycle; bcd holds the result from the next cycle on.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(BIN_W - 2);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BIN_W - 1);

    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  adj_c;
    logic [CNT_W-1:0] cnt;
    logic             running;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
    endfunction

    // Correct every BCD nibble before the shift.
    always_comb begin
        adj_c = sr;
        for (int i = 0; i < 3; i++) begin
            adj_c[BIN_W + 4*i +: 4] = add3(sr[BIN_W + 4*i +: 4]);
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            sr      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= !start && running && (cnt == CNT_PENULT);
            if (start) begin
                sr      <= {BCD_W'(0), bin};
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                sr  <= SR_W'(adj_c << 1);
                cnt <= CNT_W'(cnt + 1'b1);
                if (cnt == CNT_LAST) begin
                    running <= 1'b0;
                end
            end
        end
    end

    assign bcd = sr[SR_W-1:BIN_W];

endmodule

// File: rtl/seg7_display.sv
// Signed 8-bit value to 4-digit multiplexed common-anode seven-segment display.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros in hundreds/tens.
module seg7_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [BIN_W-1:0] value,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             busy
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic             start_c;
    logic             pending_c;
    logic [BIN_W-1:0] mag_c;
    logic [BIN_W-1:0] last;
    logic             neg;
    logic             first;
    logic             done;
    logic [BCD_W-1:0] bcd;
    logic             blank_h_c;
    logic             blank_t_c;
    logic [6:0]       ld_c [DIGITS];
    logic [6:0]       dig  [DIGITS];
    logic [DIV_W-1:0] div;
    logic [1:0]       idx;

    assign pending_c = first || (value != last);
    assign mag_c     = value[BIN_W-1] ? BIN_W'(~value + 1'b1) : value;

    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .resetn (resetn),
        .start  (start_c),
        .bin    (mag_c),
        .done   (done),
        .bcd    (bcd)
    );

    // Conversion sequencing.
    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        case (state)
            IDLE: begin
                if (pending_c) begin
                    state_nxt = CONV;
                    start_c   = 1'b1;
                end
            end
            CONV:    if (done) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            last  <= '0;
            neg   <= 1'b0;
            first <= 1'b1;
        end else if (start_c) begin
            last  <= value;
            neg   <= value[BIN_W-1];
            first <= 1'b0;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign blank_h_c = (bcd[11:8] == 4'd0);
    assign blank_t_c = blank_h_c && (bcd[7:4] == 4'd0);
`else
    assign blank_h_c = 1'b0;
    assign blank_t_c = 1'b0;
`endif

    // Segment patterns latched into the digit registers on LOAD.
    always_comb begin
        ld_c[3] = neg ? SEG_MINUS : SEG_BLANK;
        ld_c[2] = blank_h_c ? SEG_BLANK : nib2seg(bcd[11:8]);
        ld_c[1] = blank_t_c ? SEG_BLANK : nib2seg(bcd[7:4]);
        ld_c[0] = nib2seg(bcd[3:0]);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig[i] <= SEG_BLANK;
            end
        end else if (state == LOAD) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig[i] <= ld_c[i];
            end
        end
    end

    // Digit scan: an and seg follow the index on the same edge.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            div <= '0;
            idx <= '0;
            an  <= 4'hF;
            seg <= SEG_BLANK;
        end else begin
            if (div == DIV_LAST) begin
                div <= '0;
                idx <= 2'(idx + 1'b1);
            end else begin
                div <= DIV_W'(div + 1'b1);
            end
            an  <= ~(4'b0001 << idx);
            seg <= dig[idx];
        end
    end

endmodule

// File: tb/tb_seg7_display.sv
// Scoreboard bench for seg7_display: expected scan frames are queued, a monitor checks each new digit.
module tb_seg7_display;

    localparam int unsigned REFRESH_DIV = 4;
    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] MI = 7'h3F;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    logic       clk    = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] value  = 8'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [10:0] exp_q [$];
    logic [3:0]  prev_an     = 4'hF;
    string       cur_frame   = "none";

    seg7_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk    (clk),
        .resetn (resetn),
        .value  (value),
        .seg    (seg),
        .an     (an),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Edges since reset release; digit k is shown after edges 16m+4k+1..16m+4k+4.
    always @(posedge clk or posedge resetn) begin
        if (resetn) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected {an,seg} each time a new digit is presented.
    always @(negedge clk) begin
        if (!resetn) begin
            check("an_onehot", 32'(an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7}), 32'd1);
            if (an != prev_an && exp_q.size() > 0) begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check(cur_frame, {21'd0, an, seg}, {21'd0, e});
            end
        end
        prev_an = an;
    end

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic expect_busy(input string name, input int exp);
        int n;
        count_busy(n);
        check(name, 32'(n), 32'(exp));
    endtask

    task automatic check_frame(input string name, input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cyc > 0 && cyc % 16 == 0) break;
        end
        cur_frame = name;
        exp_q.push_back({4'b1110, s0});
        exp_q.push_back({4'b1101, s1});
        exp_q.push_back({4'b1011, s2});
        exp_q.push_back({4'b0111, s3});
        repeat (16) @(negedge clk);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic apply(input logic [7:0] v, input string name);
        @(negedge clk);
        value = v;
        expect_busy({name, "_busy"}, 9);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        value  = 8'd0;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);

        resetn = 1'b0;
        @(negedge clk);
        check("an_first", 32'(an), 32'hE);
        check("busy_first", 32'(busy), 32'd1);
        expect_busy("busy_first_rest", 8);
        check_frame("frame_zero", BL, LZ, LZ, 7'h40);

        apply(8'h80, "m128");
        check_frame("frame_m128", MI, 7'h79, 7'h24, 7'h00);

        apply(8'd127, "p127");
        check_frame("frame_p127", BL, 7'h79, 7'h24, 7'h78);

        apply(8'd100, "p100");
        check_frame("frame_p100", BL, 7'h79, 7'h40, 7'h40);

        apply(8'hFF, "m1");
        check_frame("frame_m1", MI, LZ, LZ, 7'h79);

        // Value changes mid-conversion: 5 completes, then -5 converts back to back.
        @(negedge clk);
        value = 8'd5;
        repeat (3) @(negedge clk);
        value = 8'hFB;
        expect_busy("busy_p5_rest", 6);
        expect_busy("busy_m5", 9);
        check_frame("frame_m5", MI, LZ, LZ, 7'h12);

        // Reset pulse in the middle of a conversion.
        @(negedge clk);
        value = 8'd42;
        repeat (3) @(negedge clk);
        check("busy_pre_rst", 32'(busy), 32'd1);
        resetn = 1'b1;
        #1;
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        expect_busy("busy_reconv", 9);
        check_frame("frame_p42", BL, LZ, 7'h19, 7'h24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
